// File: rtl/fio_pkg.sv
// rtl/fio_pkg.sv - shared target codes, state encodings and port widths for fio_sequencer
package fio_pkg;
   typedef enum logic [1:0] {
      TGT_TM     = 2'd0,
      TGT_ICACHE = 2'd1,
      TGT_MEM    = 2'd2,
      TGT_CLE    = 2'd3
   } fio_tgt_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_RUN,
      ST_DUMP_ADDR,
      ST_DUMP_WAIT,
      ST_DUMP_OUT,
      ST_DONE
   } fio_state_e;

   localparam int TM_DW     = 29;
   localparam int CLE_DW    = 5;
   localparam int ICACHE_DW = 32;
endpackage

// File: rtl/fio_addr_ctr.sv
// rtl/fio_addr_ctr.sv - saturating write-address counter with depth limit and overflow flag
// The counter parks at DEPTH so a full target keeps rejecting writes instead of wrapping.
module fio_addr_ctr #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          inc_i,
   output logic [AW-1:0] addr_o,
   output logic          full_o,
   output logic          ovf_o
);
   localparam int W = $clog2(DEPTH + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign full_o = (cnt_q == W'(DEPTH));
   assign ovf_o  = inc_i && full_o;
   assign addr_o = cnt_q[AW-1:0];

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (inc_i && !full_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/fio_sequencer.sv
// rtl/fio_sequencer.sv - loads gpu_top FileIO ports from a tagged command stream, runs it, dumps global memory
module fio_sequencer
   import fio_pkg::*;
#(
   parameter int MEM_DEPTH    = 256,
   parameter int SHMEM_DEPTH  = 256,
   parameter int ICACHE_DEPTH = 1024,
   parameter int START_CYCLES = 2
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       cmd_valid,
   output logic                                       cmd_ready,
   input  logic [1:0]                                 cmd_target,
   input  logic [255:0]                               cmd_data,
   input  logic                                       cmd_clear,
   input  logic                                       go,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       err_overflow,
   output logic                                       dump_valid,
   input  logic                                       dump_ready,
   output logic [255:0]                               dump_data,
   output logic [$clog2(MEM_DEPTH)-1:0]               dump_row,
   output logic                                       Wen_FIO_TM,
   output logic [28:0]                                Din_FIO_TM,
   output logic                                       start_FIO_TM,
   output logic                                       clear_FIO_TM,
   input  logic                                       finished_TM_FIO,
   output logic                                       Wen_FIO_ICache,
   output logic [$clog2(ICACHE_DEPTH)-1:0]            Addr_FIO_ICache,
   output logic [31:0]                                Din_FIO_ICache,
   output logic                                       Wen_FIO_MEM,
   output logic [$clog2(MEM_DEPTH+SHMEM_DEPTH)-1:0]   Addr_FIO_MEM,
   output logic [255:0]                               Din_FIO_MEM,
   input  logic [255:0]                               Dout_FIO_MEM,
   output logic                                       Wen_FIO_CLE,
   output logic [$clog2(MEM_DEPTH)-1:0]               Addr_FIO_CLE,
   output logic [4:0]                                 Din_FIO_CLE
);
   localparam int AW = $clog2(MEM_DEPTH + SHMEM_DEPTH);
   localparam int CW = $clog2(MEM_DEPTH);
   localparam int IW = $clog2(ICACHE_DEPTH);
   localparam int SW = $clog2(START_CYCLES + 1);

   fio_state_e       state_q;
   logic [SW-1:0]    start_cnt_q;
   logic [CW-1:0]    row_q;
   logic             go_q, fin_q, clr_prev_q;
   logic             wen_tm_q, wen_ic_q, wen_mem_q, wen_cle_q;
   logic [TM_DW-1:0] din_tm_q;
   logic [31:0]      din_ic_q;
   logic [255:0]     din_mem_q, dump_data_q;
   logic [CLE_DW-1:0] din_cle_q;
   logic [IW-1:0]    addr_ic_q;
   logic [AW-1:0]    addr_mem_q;
   logic [CW-1:0]    addr_cle_q, dump_row_q;
   logic             start_q, clear_q, dump_valid_q, err_q;

   logic load_st, acc, done_exit, ctr_clr;
   logic [IW-1:0] ic_addr;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] cle_addr;
   logic ic_full, mem_full, cle_full, ic_ovf, mem_ovf, cle_ovf;

   assign load_st   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign cmd_ready = load_st && !cmd_clear;
   assign acc       = cmd_valid && cmd_ready;
   assign done_exit = (state_q == ST_DONE) && go_q && !go;
   assign ctr_clr   = (load_st && cmd_clear) || done_exit;

   fio_addr_ctr #(.DEPTH(ICACHE_DEPTH), .AW(IW)) u_ctr_ic (
      .clk(clk), .rst(rst), .clear_i(ctr_clr), .inc_i(acc && cmd_target == TGT_ICACHE),
      .addr_o(ic_addr), .full_o(ic_full), .ovf_o(ic_ovf));
   fio_addr_ctr #(.DEPTH(MEM_DEPTH + SHMEM_DEPTH), .AW(AW)) u_ctr_mem (
      .clk(clk), .rst(rst), .clear_i(ctr_clr), .inc_i(acc && cmd_target == TGT_MEM),
      .addr_o(mem_addr), .full_o(mem_full), .ovf_o(mem_ovf));
   fio_addr_ctr #(.DEPTH(MEM_DEPTH), .AW(CW)) u_ctr_cle (
      .clk(clk), .rst(rst), .clear_i(ctr_clr), .inc_i(acc && cmd_target == TGT_CLE),
      .addr_o(cle_addr), .full_o(cle_full), .ovf_o(cle_ovf));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;      start_cnt_q <= '0;   row_q <= '0;
         go_q <= 1'b0;            fin_q <= 1'b0;       clr_prev_q <= 1'b0;
         wen_tm_q <= 1'b0;        wen_ic_q <= 1'b0;    wen_mem_q <= 1'b0;   wen_cle_q <= 1'b0;
         din_tm_q <= '0;          din_ic_q <= '0;      din_mem_q <= '0;     din_cle_q <= '0;
         addr_ic_q <= '0;         addr_mem_q <= '0;    addr_cle_q <= '0;
         dump_data_q <= '0;       dump_row_q <= '0;    dump_valid_q <= 1'b0;
         start_q <= 1'b0;         clear_q <= 1'b0;     err_q <= 1'b0;
      end else begin
         go_q       <= go;
         fin_q      <= finished_TM_FIO;
         clr_prev_q <= cmd_clear;
         clear_q    <= load_st && cmd_clear && !clr_prev_q;
         wen_tm_q   <= 1'b0;
         wen_ic_q   <= 1'b0;
         wen_mem_q  <= 1'b0;
         wen_cle_q  <= 1'b0;
         if (ic_ovf || mem_ovf || cle_ovf)
            err_q <= 1'b1;
         case (state_q)
            ST_IDLE, ST_LOAD: begin
               if (cmd_clear) begin
                  state_q <= ST_IDLE;
               end else if (acc) begin
                  state_q <= ST_LOAD;
                  case (cmd_target)
                     TGT_TM: begin
                        wen_tm_q <= 1'b1;
                        din_tm_q <= cmd_data[TM_DW-1:0];
                     end
                     TGT_ICACHE: if (!ic_full) begin
                        wen_ic_q  <= 1'b1;
                        addr_ic_q <= ic_addr;
                        din_ic_q  <= cmd_data[ICACHE_DW-1:0];
                     end
                     TGT_MEM: if (!mem_full) begin
                        wen_mem_q  <= 1'b1;
                        addr_mem_q <= mem_addr;
                        din_mem_q  <= cmd_data;
                     end
                     default: if (!cle_full) begin
                        wen_cle_q  <= 1'b1;
                        addr_cle_q <= cle_addr;
                        din_cle_q  <= cmd_data[CLE_DW-1:0];
                     end
                  endcase
               end else if (go) begin
                  state_q     <= ST_START;
                  start_q     <= 1'b1;
                  start_cnt_q <= '0;
               end
            end
            ST_START: begin
               if (start_cnt_q == SW'(START_CYCLES - 1)) begin
                  start_q <= 1'b0;
                  state_q <= ST_RUN;
               end else begin
                  start_cnt_q <= start_cnt_q + 1'b1;
               end
            end
            ST_RUN: if (fin_q) begin
               state_q    <= ST_DUMP_ADDR;
               row_q      <= '0;
               addr_mem_q <= '0;
            end
            ST_DUMP_ADDR: state_q <= ST_DUMP_WAIT;
            // Address was presented on entry to DUMP_ADDR, so the BRAM output is valid here.
            ST_DUMP_WAIT: begin
               state_q      <= ST_DUMP_OUT;
               dump_data_q  <= Dout_FIO_MEM;
               dump_row_q   <= row_q;
               dump_valid_q <= 1'b1;
            end
            ST_DUMP_OUT: if (dump_ready) begin
               dump_valid_q <= 1'b0;
               if (row_q == CW'(MEM_DEPTH - 1)) begin
                  state_q <= ST_DONE;
               end else begin
                  row_q      <= row_q + 1'b1;
                  addr_mem_q <= AW'(row_q + 1'b1);
                  state_q    <= ST_DUMP_ADDR;
               end
            end
            ST_DONE: if (done_exit) begin
               state_q <= ST_IDLE;
               err_q   <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy            = !load_st;
   assign done            = (state_q == ST_DONE);
   assign err_overflow    = err_q;
   assign dump_valid      = dump_valid_q;
   assign dump_data       = dump_data_q;
   assign dump_row        = dump_row_q;
   assign Wen_FIO_TM      = wen_tm_q;
   assign Din_FIO_TM      = din_tm_q;
   assign start_FIO_TM    = start_q;
   assign clear_FIO_TM    = clear_q;
   assign Wen_FIO_ICache  = wen_ic_q;
   assign Addr_FIO_ICache = addr_ic_q;
   assign Din_FIO_ICache  = din_ic_q;
   assign Wen_FIO_MEM     = wen_mem_q;
   assign Addr_FIO_MEM    = addr_mem_q;
   assign Din_FIO_MEM     = din_mem_q;
   assign Wen_FIO_CLE     = wen_cle_q;
   assign Addr_FIO_CLE    = addr_cle_q;
   assign Din_FIO_CLE     = din_cle_q;
endmodule

// File: tb/tb_fio_sequencer.sv
// tb/tb_fio_sequencer.sv - directed self-checking bench for fio_sequencer
`timescale 1ns/1ps
module tb_fio_sequencer;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cmd_valid = 1'b0, cmd_ready, cmd_clear = 1'b0, go = 1'b0;
   logic [1:0]   cmd_target = 2'd0;
   logic [255:0] cmd_data = '0;
   logic         busy, done, err_overflow, dump_valid, dump_ready = 1'b1;
   logic [255:0] dump_data;
   logic [7:0]   dump_row;
   logic         Wen_FIO_TM, start_FIO_TM, clear_FIO_TM, finished_TM_FIO = 1'b0;
   logic [28:0]  Din_FIO_TM;
   logic         Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE;
   logic [9:0]   Addr_FIO_ICache;
   logic [31:0]  Din_FIO_ICache;
   logic [8:0]   Addr_FIO_MEM;
   logic [255:0] Din_FIO_MEM, Dout_FIO_MEM;
   logic [7:0]   Addr_FIO_CLE;
   logic [4:0]   Din_FIO_CLE;

   int errors = 0;
   int checks = 0;

   fio_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_target(cmd_target), .cmd_data(cmd_data), .cmd_clear(cmd_clear), .go(go),
      .busy(busy), .done(done), .err_overflow(err_overflow), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_data(dump_data), .dump_row(dump_row),
      .Wen_FIO_TM(Wen_FIO_TM), .Din_FIO_TM(Din_FIO_TM), .start_FIO_TM(start_FIO_TM),
      .clear_FIO_TM(clear_FIO_TM), .finished_TM_FIO(finished_TM_FIO),
      .Wen_FIO_ICache(Wen_FIO_ICache), .Addr_FIO_ICache(Addr_FIO_ICache), .Din_FIO_ICache(Din_FIO_ICache),
      .Wen_FIO_MEM(Wen_FIO_MEM), .Addr_FIO_MEM(Addr_FIO_MEM), .Din_FIO_MEM(Din_FIO_MEM),
      .Dout_FIO_MEM(Dout_FIO_MEM), .Wen_FIO_CLE(Wen_FIO_CLE), .Addr_FIO_CLE(Addr_FIO_CLE),
      .Din_FIO_CLE(Din_FIO_CLE)
   );

   always #5 clk = ~clk;

   // Global memory BRAM with one cycle of read latency, as gpu_top presents it.
   logic [255:0] bram [0:511];
   always @(posedge clk) begin
      if (Wen_FIO_MEM) bram[Addr_FIO_MEM] <= Din_FIO_MEM;
      Dout_FIO_MEM <= bram[Addr_FIO_MEM];
   end

   function automatic logic [255:0] pat(input int r, input int seed);
      logic [31:0] w;
      w = (32'(r) * 32'h9E37_79B1) ^ (32'(seed) * 32'h0101_0101);
      return {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000, 32'(r), 32'(seed), w << 3, w >> 5};
   endfunction

   task automatic send(input logic [1:0] t, input logic [255:0] d);
      cmd_valid = 1'b1; cmd_target = t; cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      cmd_clear = 1'b1;
      @(posedge clk); #1;
      cmd_clear = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE, start_FIO_TM, clear_FIO_TM,
           dump_valid, busy, done, err_overflow} !== 10'b0) begin
         errors++; $display("FAIL reset_flags got=%b want=0", {Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM,
            Wen_FIO_CLE, start_FIO_TM, clear_FIO_TM, dump_valid, busy, done, err_overflow});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({Addr_FIO_ICache, Addr_FIO_MEM, Addr_FIO_CLE, Din_FIO_TM, Din_FIO_ICache, Din_FIO_CLE, dump_row} !== '0
          || Din_FIO_MEM !== '0 || dump_data !== '0) begin
         errors++; $display("FAIL reset_data addr/din/dump not zero");
      end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
   endtask

   task automatic test_icache();
      logic [31:0] d [3];
      d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1;
         checks++;
         if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ic_ready[%0d] got=%b want=1", i, cmd_ready); end
         send(2'd1, {224'd0, d[i]});
         checks++;
         if ({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE} !== 4'b0100 || Addr_FIO_ICache !== 10'(i)
             || Din_FIO_ICache !== d[i]) begin
            errors++; $display("FAIL ic_write[%0d] wen=%b addr=%0d din=%h want wen=0100 addr=%0d din=%h",
               i, {Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE}, Addr_FIO_ICache, Din_FIO_ICache, i, d[i]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (Wen_FIO_ICache !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL ic_idle wen=%b busy=%b want 0 0", Wen_FIO_ICache, busy);
      end
   endtask

   task automatic test_interleave();
      logic [255:0] m0, m1;
      m0 = pat(0, 7); m1 = pat(1, 7);
      send(2'd2, m0);
      checks++;
      if ({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE} !== 4'b0010 || Addr_FIO_MEM !== 9'd0 || Din_FIO_MEM !== m0) begin
         errors++; $display("FAIL il_mem0 wen=%b addr=%0d want 0010 addr=0", {Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE}, Addr_FIO_MEM);
      end
      send(2'd3, 256'h3F7);
      checks++;
      if ({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE} !== 4'b0001 || Addr_FIO_CLE !== 8'd0 || Din_FIO_CLE !== 5'h17) begin
         errors++; $display("FAIL il_cle0 wen=%b addr=%0d din=%h want 0001 addr=0 din=17", {Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE}, Addr_FIO_CLE, Din_FIO_CLE);
      end
      send(2'd2, m1);
      checks++;
      if ({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE} !== 4'b0010 || Addr_FIO_MEM !== 9'd1 || Din_FIO_MEM !== m1) begin
         errors++; $display("FAIL il_mem1 wen=%b addr=%0d want 0010 addr=1", {Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE}, Addr_FIO_MEM);
      end
      send(2'd0, 256'hFFFF_FFFF_ABCD);
      checks++;
      if ({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE} !== 4'b1000 || Din_FIO_TM !== 29'h1FFF_ABCD) begin
         errors++; $display("FAIL il_tm wen=%b din=%h want 1000 din=1fffabcd", {Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE}, Din_FIO_TM);
      end
   endtask

   task automatic test_clear();
      int pulses = 0;
      cmd_clear = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got=%b want=0", cmd_ready); end
      repeat (3) begin @(posedge clk); #1; if (clear_FIO_TM) pulses++; end
      cmd_clear = 1'b0;
      @(posedge clk); #1; if (clear_FIO_TM) pulses++;
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL clr_pulse got=%0d cycles want=1", pulses); end
      send(2'd1, 256'h44);
      checks++;
      if (Wen_FIO_ICache !== 1'b1 || Addr_FIO_ICache !== 10'd0) begin
         errors++; $display("FAIL clr_ic_addr wen=%b addr=%0d want 1 0", Wen_FIO_ICache, Addr_FIO_ICache);
      end
      send(2'd2, 256'h55);
      checks++;
      if (Wen_FIO_MEM !== 1'b1 || Addr_FIO_MEM !== 9'd0) begin
         errors++; $display("FAIL clr_mem_addr wen=%b addr=%0d want 1 0", Wen_FIO_MEM, Addr_FIO_MEM);
      end
   endtask

   task automatic test_overflow();
      int nwr = 0, bad = 0, maxa = 0;
      logic err_before = 1'b1, last_wen = 1'b1;
      pulse_clear();
      for (int i = 0; i < 1025; i++) begin
         send(2'd1, 256'(i));
         if (Wen_FIO_ICache) begin
            nwr++;
            if (int'(Addr_FIO_ICache) > maxa) maxa = int'(Addr_FIO_ICache);
            if (Addr_FIO_ICache !== 10'(i) || Din_FIO_ICache !== 32'(i)) bad++;
         end
         if (i == 1023) err_before = err_overflow;
         if (i == 1024) last_wen = Wen_FIO_ICache;
      end
      checks++;
      if (nwr !== 1024) begin errors++; $display("FAIL ovf_writes got=%0d want=1024", nwr); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL ovf_addr_data got=%0d bad writes want=0", bad); end
      checks++;
      if (maxa !== 1023) begin errors++; $display("FAIL ovf_max_addr got=%0d want=1023", maxa); end
      checks++;
      if (last_wen !== 1'b0) begin errors++; $display("FAIL ovf_dropped got wen=%b want=0", last_wen); end
      checks++;
      if (err_before !== 1'b0 || err_overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_flag before=%b after=%b want 0 1", err_before, err_overflow);
      end
   endtask

   task automatic load_mem(input int seed);
      int bad = 0;
      pulse_clear();
      for (int r = 0; r < 256; r++) begin
         send(2'd2, pat(r, seed));
         if (Wen_FIO_MEM !== 1'b1 || Addr_FIO_MEM !== 9'(r) || Din_FIO_MEM !== pat(r, seed)) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL load_mem seed=%0d got=%0d bad writes want=0", seed, bad); end
   endtask

   task automatic run_dump(input int seed, input int stall_row, input int abort_row);
      int cyc = 0, starts = 0, exp_row = 0, stall = 0, unstable = 0, rowbad = 0;
      logic done_seen = 1'b0, aborted = 1'b0;
      logic [255:0] held_data;
      logic [7:0] held_row;
      held_data = '0; held_row = '0;
      go = 1'b1; finished_TM_FIO = 1'b0; dump_ready = 1'b1;
      while (!done_seen && !aborted && cyc < 2000) begin
         @(posedge clk); #1; cyc++;
         if (start_FIO_TM) starts++;
         if (cyc == 50) finished_TM_FIO = 1'b1;
         if (dump_valid) begin
            if (abort_row >= 0 && exp_row == abort_row) begin
               aborted = 1'b1;
            end else if (stall_row >= 0 && exp_row == stall_row && stall < 10) begin
               dump_ready = 1'b0;
               if (stall == 0) begin held_data = dump_data; held_row = dump_row; end
               else if (dump_data !== held_data || dump_row !== held_row) unstable++;
               stall++;
            end else begin
               dump_ready = 1'b1;
               if (dump_row !== 8'(exp_row) || dump_data !== pat(exp_row, seed)) begin
                  rowbad++;
                  if (rowbad < 4) $display("FAIL dump_row_data row got=%0d want=%0d data_ok=%b",
                     dump_row, exp_row, dump_data === pat(exp_row, seed));
               end
               exp_row++;
            end
         end
         if (done) done_seen = 1'b1;
      end
      checks++;
      if (rowbad !== 0) begin errors++; $display("FAIL dump_rows got=%0d bad rows want=0", rowbad); end
      checks++;
      if (starts !== 2) begin errors++; $display("FAIL start_width got=%0d cycles want=2", starts); end
      if (stall_row >= 0) begin
         checks++;
         if (stall !== 10 || unstable !== 0) begin
            errors++; $display("FAIL stall_hold stall=%0d unstable=%0d want 10 0", stall, unstable);
         end
      end
      if (aborted) begin
         rst = 1'b1;
         #1;
         checks++;
         if ({Wen_FIO_TM, Wen_FIO_ICache, Wen_FIO_MEM, Wen_FIO_CLE, start_FIO_TM, clear_FIO_TM,
              dump_valid, busy, done, err_overflow} !== 10'b0
             || {Addr_FIO_ICache, Addr_FIO_MEM, Addr_FIO_CLE, Din_FIO_TM, Din_FIO_ICache, Din_FIO_CLE, dump_row} !== '0
             || Din_FIO_MEM !== '0 || dump_data !== '0) begin
            errors++; $display("FAIL mid_dump_reset outputs not at reset values (busy=%b valid=%b row=%0d)", busy, dump_valid, dump_row);
         end
         go = 1'b0; finished_TM_FIO = 1'b0; dump_ready = 1'b1;
         @(posedge clk); #1 rst = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset ready=%b busy=%b want 1 0", cmd_ready, busy);
         end
      end else begin
         checks++;
         if (!done_seen || exp_row !== 256) begin
            errors++; $display("FAIL dump_complete done=%b rows=%0d want 1 256", done_seen, exp_row);
         end
         checks++;
         if (done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL done_state done=%b busy=%b want 1 1", done, busy);
         end
         go = 1'b0;
         @(posedge clk); #1;
         finished_TM_FIO = 1'b0;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || err_overflow !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL done_exit done=%b busy=%b err=%b ready=%b want 0 0 0 1", done, busy, err_overflow, cmd_ready);
         end
      end
   endtask

   task automatic test_dump();
      load_mem(1);
      checks++;
      if (err_overflow !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err_overflow); end
      run_dump(1, 5, -1);
   endtask

   task automatic test_reset_mid_dump();
      load_mem(2);
      run_dump(2, -1, 100);
      load_mem(3);
      run_dump(3, -1, -1);
   endtask

   initial begin
      test_reset();
      test_icache();
      test_interleave();
      test_clear();
      test_overflow();
      test_dump();
      test_reset_mid_dump();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fio_sequencer.md
# fio_sequencer

Host-side controller for the gpu_top FileIO ports. It accepts a tagged command stream and writes each word, with auto-incrementing addresses, into the TM, ICache, MEM or CLE init port. It then pulses start_FIO_TM, waits for finished_TM_FIO and streams the global-memory rows back out. It sits between a host link (UART or JTAG bridge) and gpu_top, and replaces bench-driven initialisation in hardware builds.

## Interface
Parameters:
- MEM_DEPTH, 256, global memory rows; also the number of rows dumped.
- SHMEM_DEPTH, 256, shared memory rows; MEM write address space is MEM_DEPTH+SHMEM_DEPTH.
- ICACHE_DEPTH, 1024, instruction words.
- START_CYCLES, 2, width of the start_FIO_TM pulse in cycles.

Ports (AW = clog2(MEM_DEPTH+SHMEM_DEPTH), CW = clog2(MEM_DEPTH)):
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command word offered.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_target  in  2  0=TM, 1=ICache, 2=MEM, 3=CLE.
- cmd_data  in  256  payload, LSB-aligned.
- cmd_clear  in  1  level; resets address counters and pulses clear_FIO_TM.
- go  in  1  level; launch execution.
- busy  out  1  high in every state except IDLE and LOAD.
- done  out  1  high in DONE.
- err_overflow  out  1  sticky; a write exceeded its target depth.
- dump_valid  out  1  dump_data holds a row.
- dump_ready  in  1  consumer accepts the row.
- dump_data  out  256  row contents.
- dump_row  out  CW  index of the row in dump_data.
- Wen_FIO_TM  out  1
- Din_FIO_TM  out  29
- start_FIO_TM  out  1
- clear_FIO_TM  out  1
- finished_TM_FIO  in  1
- Wen_FIO_ICache  out  1
- Addr_FIO_ICache  out  clog2(ICACHE_DEPTH)
- Din_FIO_ICache  out  32
- Wen_FIO_MEM  out  1
- Addr_FIO_MEM  out  AW
- Din_FIO_MEM  out  256
- Dout_FIO_MEM  in  256
- Wen_FIO_CLE  out  1
- Addr_FIO_CLE  out  CW
- Din_FIO_CLE  out  5

## Operation
- States:
  - IDLE
  - LOAD
  - START
  - RUN
  - DUMP_ADDR
  - DUMP_WAIT
  - DUMP_OUT
  - DONE
- IDLE/LOAD:
  - cmd_ready is 1; every accepted command produces one write to its target, and the first accepted command moves IDLE to LOAD.
  - Each target has its own address counter, starting at 0 and incremented after each write.
  - Din is cmd_data truncated to the port width.
  - TM has no address; TM ordering is the FIFO order of commands.
- Overflow: a write whose counter equals the target depth (ICACHE_DEPTH, MEM_DEPTH+SHMEM_DEPTH, MEM_DEPTH for CLE) is dropped, sets err_overflow, and the counter does not wrap. TM has no depth limit.
- cmd_clear in IDLE/LOAD:
  - zeroes all counters;
  - asserts clear_FIO_TM for exactly 1 cycle;
  - returns the block to IDLE.
  - cmd_clear is ignored in other states.
- go with cmd_valid=0 in IDLE/LOAD moves to START. If cmd_valid=1, the command is accepted and go is re-evaluated next cycle.
- START:
  - start_FIO_TM=1 for START_CYCLES cycles;
  - cmd_ready=0 from START onward;
  - then moves to RUN.
- RUN: waits for finished_TM_FIO=1, then moves to DUMP_ADDR with the row counter at 0.
- DUMP_ADDR: drives Addr_FIO_MEM=row.
- DUMP_WAIT: waits one cycle (BRAM read latency 1).
- DUMP_OUT:
  - Dout_FIO_MEM is captured at entry into dump_data, with dump_row=row and dump_valid=1.
  - dump_data is held until dump_ready. On the handshake: row+1 and go to DUMP_ADDR, or go to DONE after row MEM_DEPTH-1.
- DONE: done=1. A falling edge of go returns to IDLE with counters and err_overflow cleared.

## Timing
- Reset (any state, mid-load or mid-dump):
  - state IDLE;
  - all Wen_*, start_FIO_TM, clear_FIO_TM, dump_valid, busy, done, err_overflow = 0;
  - all addresses, Din_* and dump_data = 0;
  - cmd_ready = 1 after reset deasserts.
- Write latency: a command accepted at edge N drives Wen=1 with its address and data for the single cycle after edge N. Back-to-back commands give one write per cycle.
- Wen_* deasserts one cycle after the last command; at most one Wen_* is high per cycle.
- go → START adds 1 cycle; start_FIO_TM is registered.
- finished_TM_FIO is sampled registered; it must remain high until the dump ends.
- Dump throughput is 3 cycles/row with dump_ready held at 1. Addr_FIO_MEM is stable for ≥2 cycles before capture.

## Structure
- fio_pkg (include file) holds:
  - target codes TGT_TM/TGT_ICACHE/TGT_MEM/TGT_CLE;
  - state encodings;
  - the TM data width 29 and CLE data width 5.
- One sub-module, fio_addr_ctr: a saturating counter with depth limit, overflow flag and synchronous clear. It is instantiated per addressed target.

## Test plan
- Reset, then 3 ICache commands 0x11,0x22,0x33 → Wen_FIO_ICache high 3 consecutive cycles at addresses 0,1,2 with matching Din; cmd_ready stays 1.
- Interleave MEM, CLE, MEM, TM commands → MEM addresses 0,1; CLE address 0 with Din=cmd_data[4:0]; TM Din=cmd_data[28:0].
- 1025 ICache writes → the last write is dropped, err_overflow=1, and Addr_FIO_ICache never exceeds 1023.
- go with finished_TM_FIO asserted 50 cycles later and dump_ready=1 → start_FIO_TM high exactly 2 cycles; 256 rows emitted with dump_row 0..255 in order and data matching the MEM model; then done=1.
- dump_ready held 0 for 10 cycles on row 5 → dump_data and dump_row stable; no row skipped or repeated.
- rst asserted during row 100 of the dump → all outputs at reset values immediately. A new load and go afterwards dumps from row 0.
